// File: rtl/pwm_period_sequencer_pkg.sv
// pwm_period_sequencer_pkg: mode and state encodings shared by the sequencer and the PWM counter
package pwm_period_sequencer_pkg;
  localparam logic [1:0] MODE_OFF = 2'd0, MODE_UP = 2'd1, MODE_DOWN = 2'd2, MODE_UP_DOWN = 2'd3;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STOPPING = 2'd2} state_t;
endpackage

// File: rtl/pwm_shadow_regs.sv
// pwm_shadow_regs: host-written shadow config, active config and the pending-update flag
module pwm_shadow_regs
  import pwm_period_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr_en,
  input  logic [WIDTH-1:0]     i_wr_period,
  input  logic [1:0]           i_wr_mode,
  input  logic [REP_WIDTH-1:0] i_wr_reps,
  input  logic                 i_commit,
  output logic [1:0]           o_mode,
  output logic [WIDTH-1:0]     o_period,
  output logic [1:0]           o_shadow_mode,
  output logic [REP_WIDTH-1:0] o_shadow_reps,
  output logic                 o_pending
);
  logic [WIDTH-1:0] shadow_period;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      shadow_period <= '0;
      o_shadow_mode <= MODE_OFF;
      o_shadow_reps <= '0;
      o_mode        <= MODE_OFF;
      o_period      <= '0;
      o_pending     <= 1'b0;
    end else begin
      if (i_wr_en) begin
        shadow_period <= i_wr_period;
        o_shadow_mode <= i_wr_mode;
        o_shadow_reps <= i_wr_reps;
      end
      if (i_commit) begin
        o_mode   <= o_shadow_mode;
        o_period <= shadow_period;
      end
      // a write landing on a commit edge keeps the new values pending
      o_pending <= i_wr_en | (o_pending & ~i_commit);
    end
  end
endmodule

// File: rtl/pwm_period_sequencer.sv
// pwm_period_sequencer: run control and boundary-synchronous config commit for the PWM period counter
module pwm_period_sequencer
  import pwm_period_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr_en,
  input  logic [WIDTH-1:0]     i_wr_period,
  input  logic [1:0]           i_wr_mode,
  input  logic [REP_WIDTH-1:0] i_wr_reps,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_abort,
  input  logic                 i_tick,
  input  logic [WIDTH-1:0]     i_cnt_value,
  output logic                 o_cnt_en,
  output logic                 o_cnt_clear,
  output logic [1:0]           o_mode,
  output logic [WIDTH-1:0]     o_period,
  output logic                 o_sync_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_update_pending,
  output logic [REP_WIDTH-1:0] o_reps_left
);
  state_t state_q, state_d;
  logic [REP_WIDTH-1:0] reps_q, reps_d, shadow_reps;
  logic [1:0] shadow_mode;
  logic first_q, first_d, commit, finish, running, idle, term, boundary, start_ok;
  pwm_shadow_regs #(.WIDTH(WIDTH), .REP_WIDTH(REP_WIDTH)) u_shadow (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_wr_en(i_wr_en),
    .i_wr_period(i_wr_period),
    .i_wr_mode(i_wr_mode),
    .i_wr_reps(i_wr_reps),
    .i_commit(commit),
    .o_mode(o_mode),
    .o_period(o_period),
    .o_shadow_mode(shadow_mode),
    .o_shadow_reps(shadow_reps),
    .o_pending(o_update_pending)
  );
  assign idle     = state_q == ST_IDLE;
  assign running  = !idle;
  // UP_DOWN starts from the cleared 0, so that first tick is not a return to 0
  assign term     = (o_mode == MODE_UP)      ? i_cnt_value == o_period :
                    (o_mode == MODE_DOWN)    ? i_cnt_value == '0 :
                    (o_mode == MODE_UP_DOWN) ? i_cnt_value == '0 && !first_q : 1'b0;
  assign boundary = running & i_tick & term;
  assign start_ok = i_start && shadow_mode != MODE_OFF;
  assign o_cnt_en    = running & i_tick;
  assign o_sync_en   = running;
  assign o_busy      = running;
  assign o_reps_left = reps_q;
  always_comb begin
    state_d = state_q;
    reps_d  = reps_q;
    first_d = first_q & ~(running & i_tick);
    commit  = 1'b0;
    finish  = 1'b0;
    if (idle) begin
      commit = o_update_pending | start_ok;
      if (start_ok) begin
        state_d = ST_RUN;
        reps_d  = shadow_reps;
        first_d = 1'b1;
      end
    end else if (i_abort || (boundary && (i_stop || state_q == ST_STOPPING))) begin
      finish = 1'b1;
    end else if (i_stop) begin
      state_d = ST_STOPPING;
    end else if (boundary) begin
      commit = o_update_pending;
      reps_d = (reps_q != '0) ? reps_q - REP_WIDTH'(1) : reps_q;
      finish = (o_update_pending && shadow_mode == MODE_OFF) || reps_q == REP_WIDTH'(1);
    end
    if (finish) state_d = ST_IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      reps_q      <= '0;
      first_q     <= 1'b0;
      o_cnt_clear <= 1'b1;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reps_q      <= reps_d;
      first_q     <= first_d;
      o_cnt_clear <= finish | (o_cnt_clear & ~(idle & start_ok));
      o_done      <= finish;
    end
  end
endmodule

// File: tb/tb_pwm_period_sequencer.sv
// tb_pwm_period_sequencer: scoreboard bench driving the sequencer with a behavioural PWM counter
module tb_pwm_period_sequencer;
  import pwm_period_sequencer_pkg::*;
  localparam int W = 16, RW = 8;
  logic i_clk = 1'b0, i_reset_n = 1'b0, i_wr_en = 1'b0, i_start = 1'b0, i_stop = 1'b0, i_abort = 1'b0, i_tick = 1'b0;
  logic [W-1:0] i_wr_period = '0, cnt = '0;
  logic [1:0] i_wr_mode = '0;
  logic [RW-1:0] i_wr_reps = '0, prev_reps = '0;
  logic o_cnt_en, o_cnt_clear, o_sync_en, o_busy, o_done, o_update_pending, dir_dn = 1'b0;
  logic [1:0] o_mode;
  logic [W-1:0] o_period;
  logic [RW-1:0] o_reps_left;
  int cyc = 0, tick_div = 1, n_checks = 0, n_errors = 0, s = 0;
  int done_exp[$];
  logic [RW-1:0] reps_exp[$];
  pwm_period_sequencer #(.WIDTH(W), .REP_WIDTH(RW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr_en(i_wr_en), .i_wr_period(i_wr_period),
    .i_wr_mode(i_wr_mode), .i_wr_reps(i_wr_reps), .i_start(i_start), .i_stop(i_stop),
    .i_abort(i_abort), .i_tick(i_tick), .i_cnt_value(cnt), .o_cnt_en(o_cnt_en),
    .o_cnt_clear(o_cnt_clear), .o_mode(o_mode), .o_period(o_period), .o_sync_en(o_sync_en),
    .o_busy(o_busy), .o_done(o_done), .o_update_pending(o_update_pending), .o_reps_left(o_reps_left)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(posedge i_clk) begin
    if (o_cnt_clear) begin
      cnt <= '0;
      dir_dn <= 1'b0;
    end else if (o_cnt_en) begin
      if (o_mode == MODE_UP) cnt <= (cnt == o_period) ? '0 : cnt + W'(1);
      else if (o_mode == MODE_DOWN) cnt <= (cnt == '0) ? o_period : cnt - W'(1);
      else if (o_mode == MODE_UP_DOWN) begin
        if (!dir_dn && cnt == o_period) begin cnt <= cnt - W'(1); dir_dn <= 1'b1; end
        else if (dir_dn && cnt == '0) begin cnt <= cnt + W'(1); dir_dn <= 1'b0; end
        else cnt <= dir_dn ? cnt - W'(1) : cnt + W'(1);
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask
  always @(negedge i_clk) begin
    if (o_reps_left != prev_reps) begin
      if (reps_exp.size() == 0) check("reps_unexpected", 32'(o_reps_left), 32'(prev_reps));
      else check("reps_left", 32'(o_reps_left), 32'(reps_exp.pop_front()));
      prev_reps = o_reps_left;
    end
    if (o_done) begin
      if (done_exp.size() == 0) check("done_unexpected", 32'(o_done), 32'(0));
      else check("done_cycle", cyc, done_exp.pop_front());
    end
  end
  task automatic step();
    @(posedge i_clk);
    #1;
    i_tick = (tick_div <= 1) || (cyc % tick_div == 0);
    #1;
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask
  task automatic write_cfg(input logic [W-1:0] p, input logic [1:0] m, input logic [RW-1:0] r);
    i_wr_en = 1'b1;
    i_wr_period = p;
    i_wr_mode = m;
    i_wr_reps = r;
    step();
    i_wr_en = 1'b0;
  endtask
  task automatic start_run(output int t);
    t = cyc;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'(0));
    check({tag, "_clear"}, 32'(o_cnt_clear), 32'(1));
    check({tag, "_mode"}, 32'(o_mode), 32'(0));
    check({tag, "_period"}, 32'(o_period), 32'(0));
    check({tag, "_pending"}, 32'(o_update_pending), 32'(0));
    check({tag, "_reps"}, 32'(o_reps_left), 32'(0));
    check({tag, "_done"}, 32'(o_done), 32'(0));
    check({tag, "_cnt_en"}, 32'(o_cnt_en), 32'(0));
  endtask
  initial begin
    step();
    step();
    check_reset_outputs("reset");
    i_reset_n = 1'b1;
    step();
    // burst of three UP periods
    write_cfg(16'd4, MODE_UP, 8'd3);
    step();
    reps_exp.push_back(8'd3); reps_exp.push_back(8'd2); reps_exp.push_back(8'd1); reps_exp.push_back(8'd0);
    done_exp.push_back(cyc + 16);
    start_run(s);
    check("start_clear", 32'(o_cnt_clear), 32'(0));
    check("start_busy", 32'(o_busy), 32'(1));
    check("start_period", 32'(o_period), 32'(4));
    check("start_mode", 32'(o_mode), 32'(MODE_UP));
    wait_until(s + 15);
    check("burst_busy_last", 32'(o_busy), 32'(1));
    wait_until(s + 17);
    check("burst_clear_after", 32'(o_cnt_clear), 32'(1));
    check("burst_busy_after", 32'(o_busy), 32'(0));
    // mid-period update takes effect only after the boundary
    write_cfg(16'd9, MODE_UP, 8'd0);
    step();
    start_run(s);
    wait_until(s + 4);
    write_cfg(16'd5, MODE_UP, 8'd0);
    check("upd_pending_set", 32'(o_update_pending), 32'(1));
    check("upd_period_hold", 32'(o_period), 32'(9));
    wait_until(s + 10);
    check("upd_period_at_bnd", 32'(o_period), 32'(9));
    step();
    check("upd_period_new", 32'(o_period), 32'(5));
    check("upd_pending_clr", 32'(o_update_pending), 32'(0));
    done_exp.push_back(cyc + 1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("upd_abort_idle", 32'(o_busy), 32'(0));
    step();
    // graceful stop in DOWN mode
    write_cfg(16'd6, MODE_DOWN, 8'd0);
    step();
    start_run(s);
    done_exp.push_back(s + 9);
    wait_until(s + 4);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    check("stop_busy", 32'(o_busy), 32'(1));
    check("stop_sync_en", 32'(o_sync_en), 32'(1));
    check("stop_cnt_en", 32'(o_cnt_en), 32'(1));
    wait_until(s + 8);
    check("stop_busy_before_zero", 32'(o_busy), 32'(1));
    wait_until(s + 9);
    check("stop_idle", 32'(o_busy), 32'(0));
    check("stop_clear", 32'(o_cnt_clear), 32'(1));
    step();
    // abort together with stop on a boundary, with an update pending
    write_cfg(16'd4, MODE_UP, 8'd0);
    step();
    start_run(s);
    wait_until(s + 2);
    write_cfg(16'd7, MODE_UP, 8'd0);
    wait_until(s + 5);
    done_exp.push_back(s + 6);
    i_abort = 1'b1;
    i_stop = 1'b1;
    step();
    i_abort = 1'b0;
    i_stop = 1'b0;
    check("abort_idle", 32'(o_busy), 32'(0));
    check("abort_clear", 32'(o_cnt_clear), 32'(1));
    check("abort_no_commit", 32'(o_period), 32'(4));
    check("abort_pending", 32'(o_update_pending), 32'(1));
    step();
    check("abort_idle_commit", 32'(o_period), 32'(7));
    // UP_DOWN with a tick every third cycle
    tick_div = 3;
    write_cfg(16'd3, MODE_UP_DOWN, 8'd2);
    step();
    while (cyc % 3 != 0) step();
    reps_exp.push_back(8'd2); reps_exp.push_back(8'd1); reps_exp.push_back(8'd0);
    start_run(s);
    done_exp.push_back(s + 40);
    wait_until(s + 4);
    check("ud_no_tick_en", 32'(o_cnt_en), 32'(0));
    wait_until(s + 6);
    check("ud_tick_en", 32'(o_cnt_en), 32'(1));
    wait_until(s + 39);
    check("ud_busy_last", 32'(o_busy), 32'(1));
    wait_until(s + 40);
    check("ud_idle", 32'(o_busy), 32'(0));
    tick_div = 1;
    step();
    // reset mid-run, then starts with shadow mode OFF
    write_cfg(16'd4, MODE_UP, 8'd5);
    step();
    reps_exp.push_back(8'd5); reps_exp.push_back(8'd0);
    start_run(s);
    wait_until(s + 3);
    i_reset_n = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check_reset_outputs("midrun_reset");
    i_reset_n = 1'b1;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    check("off_start_busy", 32'(o_busy), 32'(0));
    write_cfg(16'd8, MODE_OFF, 8'd2);
    step();
    check("off_idle_commit", 32'(o_period), 32'(8));
    check("off_pending", 32'(o_update_pending), 32'(0));
    start_run(s);
    check("off_start2_busy", 32'(o_busy), 32'(0));
    check("off_start2_clear", 32'(o_cnt_clear), 32'(1));
    step();
    step();
    check("done_exp_empty", 32'(done_exp.size()), 32'(0));
    check("reps_exp_empty", 32'(reps_exp.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
